// File: rtl/poly_mult_ctrl.sv
// Sequencer for the pointwise coefficient multiplier: streams N operand reads,
// then writes the realigned multiplier results to the destination BRAM.
module poly_mult_ctrl #(
    parameter int N        = 1024,
    parameter int ADDR_W   = 10,
    parameter int RAM_LAT  = 1,
    parameter int LAT_PRE  = 4,
    parameter int LAT_NORM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              precomp_in,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mult_en,
    output logic              mult_precomp,
    input  logic [15:0]       mult_dout,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    localparam int VLD_W = RAM_LAT + ((LAT_PRE > LAT_NORM) ? LAT_PRE : LAT_NORM);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [VLD_W-1:0]  vld_q, vld_d;
    logic              wr_fire;

    // The valid tap follows the latched mode, so the write lands exactly L cycles after the read.
    assign wr_fire = mode_q ? vld_q[RAM_LAT+LAT_PRE-1] : vld_q[RAM_LAT+LAT_NORM-1];

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign rd_en        = (state_q == S_RUN);
    assign rd_addr      = rd_cnt_q;
    assign mult_en      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign mult_precomp = mult_en & mode_q;
    assign wr_en        = wr_fire;
    assign wr_addr      = wr_cnt_q;
    assign wr_data      = mult_dout;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        vld_d    = {vld_q[VLD_W-2:0], rd_en};
        if (wr_fire && (wr_cnt_q != LAST)) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = precomp_in;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (wr_fire && (wr_cnt_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                vld_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_poly_mult_ctrl.sv
// Directed bench for poly_mult_ctrl with N=8; a multiplier stub returns 100+addr
// after the mode-dependent latency.
module tb_poly_mult_ctrl;

    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int L_NORM = 9;
    localparam int L_PRE  = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              precomp_in;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mult_en;
    logic              mult_precomp;
    logic [15:0]       mult_dout;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    int n_cmp = 0;
    int n_err = 0;

    poly_mult_ctrl #(
        .N(N), .ADDR_W(ADDR_W), .RAM_LAT(1), .LAT_PRE(4), .LAT_NORM(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .precomp_in(precomp_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .mult_en(mult_en), .mult_precomp(mult_precomp), .mult_dout(mult_dout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier stub: address history, tapped at L-1 for the current mode
    logic [ADDR_W-1:0] addr_pipe [0:8];
    always @(posedge clk) begin
        addr_pipe[0] <= rd_addr;
        for (int j = 1; j < 9; j++) addr_pipe[j] <= addr_pipe[j-1];
    end
    always_comb begin
        mult_dout = 16'd100 + 16'(mult_precomp ? addr_pipe[L_PRE-1] : addr_pipe[L_NORM-1]);
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; precomp_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, rd_en, mult_en, mult_precomp, wr_en} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl got %b exp 000000", {busy, done, rd_en, mult_en, mult_precomp, wr_en});
        end
        n_cmp++;
        if ({rd_addr, wr_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_addr got rd=%0d wr=%0d exp 0 0", rd_addr, wr_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, rd_en, wr_en} !== 4'b0) begin
            n_err++;
            $display("FAIL post_reset_idle got %b exp 0000", {busy, done, rd_en, wr_en});
        end
    endtask

    // One full operation; start is asserted in the current cycle and sampled at edge 0.
    // start_mask bit c raises start during cycle c; tail adds idle cycles after done.
    task automatic do_run(input logic pc, input bit toggle, input logic [31:0] start_mask,
                          input int tail, input string name);
        int lat, d_cyc, wr_seen, done_seen;
        logic e_rd, e_wr, e_busy, e_done;
        lat = pc ? L_PRE : L_NORM;
        d_cyc = N + lat + 1;
        wr_seen = 0;
        done_seen = 0;
        start = 1'b1;
        precomp_in = pc;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= d_cyc + tail; c++) begin
            @(negedge clk);
            e_rd   = (c <= N);
            e_wr   = (c >= 1 + lat) && (c <= N + lat);
            e_busy = (c <= d_cyc);
            e_done = (c == d_cyc);
            n_cmp++;
            if ({busy, done, rd_en, wr_en} !== {e_busy, e_done, e_rd, e_wr}) begin
                n_err++;
                $display("FAIL %s ctl c=%0d got busy/done/rd/wr=%b exp %b", name, c,
                         {busy, done, rd_en, wr_en}, {e_busy, e_done, e_rd, e_wr});
            end
            if (e_rd) begin
                n_cmp++;
                if (rd_addr !== ADDR_W'(c - 1)) begin
                    n_err++;
                    $display("FAIL %s rd_addr c=%0d got %0d exp %0d", name, c, rd_addr, c - 1);
                end
            end
            if (e_wr) begin
                n_cmp++;
                if (wr_addr !== ADDR_W'(c - 1 - lat) || wr_data !== 16'(100 + c - 1 - lat)) begin
                    n_err++;
                    $display("FAIL %s write c=%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                             name, c, wr_addr, wr_data, c - 1 - lat, 100 + c - 1 - lat);
                end
            end
            if (c <= N + lat) begin
                n_cmp++;
                if ({mult_en, mult_precomp} !== {1'b1, pc}) begin
                    n_err++;
                    $display("FAIL %s mult c=%0d got en/pc=%b exp %b", name, c,
                             {mult_en, mult_precomp}, {1'b1, pc});
                end
            end
            if (c > d_cyc) begin
                n_cmp++;
                if ({mult_en, mult_precomp} !== 2'b00 || rd_addr !== '0 || wr_addr !== '0) begin
                    n_err++;
                    $display("FAIL %s idle c=%0d got en/pc=%b rd=%0d wr=%0d exp 00 0 0", name, c,
                             {mult_en, mult_precomp}, rd_addr, wr_addr);
                end
            end
            if (wr_en === 1'b1) wr_seen++;
            if (done === 1'b1) done_seen++;
            if (toggle) precomp_in = ~precomp_in;
            start = start_mask[c];
        end
        start = 1'b0;
        n_cmp++;
        if (wr_seen != N || done_seen != 1) begin
            n_err++;
            $display("FAIL %s counts got writes=%0d dones=%0d exp %0d 1", name, wr_seen, done_seen, N);
        end
    endtask

    task automatic test_normal();
        do_run(1'b0, 1'b0, 32'h0, 2, "normal");
    endtask

    task automatic test_precomp();
        do_run(1'b1, 1'b0, 32'h0, 2, "precomp");
    endtask

    task automatic test_mode_latch();
        do_run(1'b1, 1'b1, 32'h0, 2, "mode_latch");
    endtask

    // start during RUN (c=3), DRAIN (c=10) and the done cycle (c=18), then a start right after done
    task automatic test_start_ignored();
        logic [31:0] mask;
        mask = '0;
        mask[3]  = 1'b1;
        mask[10] = 1'b1;
        mask[18] = 1'b1;
        do_run(1'b0, 1'b0, mask, 1, "start_ignored");
        do_run(1'b0, 1'b0, 32'h0, 2, "restart");
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1;
        precomp_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                n_cmp++;
                if (rd_en !== 1'b1 || rd_addr !== ADDR_W'(c - 1)) begin
                    n_err++;
                    $display("FAIL rst_mid pre c=%0d got rd_en=%b addr=%0d exp 1 %0d", c, rd_en, rd_addr, c - 1);
                end
            end else begin
                n_cmp++;
                if ({busy, done, rd_en, mult_en, mult_precomp, wr_en} !== 6'b0 ||
                    rd_addr !== '0 || wr_addr !== '0) begin
                    n_err++;
                    $display("FAIL rst_mid post c=%0d got ctl=%b rd=%0d wr=%0d exp 000000 0 0", c,
                             {busy, done, rd_en, mult_en, mult_precomp, wr_en}, rd_addr, wr_addr);
                end
            end
            if (c == 5) rst = 1'b1;
            if (c == 6) rst = 1'b0;
        end
        do_run(1'b0, 1'b0, 32'h0, 2, "after_rst");
    endtask

    task automatic test_back_to_back();
        do_run(1'b1, 1'b0, 32'h0, 1, "b2b_precomp");
        do_run(1'b0, 1'b0, 32'h0, 2, "b2b_normal");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_precomp();
        test_mode_latch();
        test_start_ignored();
        test_rst_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_mult_ctrl.md
Name: poly_mult_ctrl

Overview:
- Sequencer that drives the pointwise coefficient multiplier over one full polynomial.
- Issues read addresses to the two operand BRAMs and holds the multiplier pipeline enabled and in the selected mode.
- Re-aligns the multiplier output with a delayed address and writes results to the destination BRAM.
- Sits between the top-level NTT/poly controller (start/done handshake) and the multiplier datapath plus its BRAMs.

Parameters:
- N, 1024, number of coefficients per polynomial.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= N.
- RAM_LAT, 1, BRAM read latency in cycles, from rd_addr to doa/dob valid at the multiplier inputs.
- LAT_PRE, 4, multiplier latency in precomp mode, from doa/dob valid to mult_dout valid.
- LAT_NORM, 8, multiplier latency in normal mode (R^2 conversion path plus second reduction).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- precomp_in  in  1  mode select; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.
- rd_en  out  1  operand BRAM read enable.
- rd_addr  out  ADDR_W  operand BRAM read address; the same address goes to both BRAMs.
- mult_en  out  1  multiplier pipeline enable.
- mult_precomp  out  1  latched mode, driven to the multiplier.
- mult_dout  in  16  multiplier result.
- wr_en  out  1  destination BRAM write enable.
- wr_addr  out  ADDR_W  destination address.
- wr_data  out  16  destination data; equals mult_dout combinationally.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, mult_en=0, mult_precomp=0, wr_en=0, wr_addr=0. The FSM goes to IDLE and the valid pipeline is cleared.
- L (total latency) = RAM_LAT + (mode ? LAT_PRE : LAT_NORM), using the latched mode.
- FSM states:
  - IDLE: if start=1, latch precomp_in into mode and go to RUN.
  - RUN: rd_en=1; rd_addr counts 0..N-1, one address per cycle, with no bubbles. After issuing N-1, go to DRAIN.
  - DRAIN: rd_en=0. Wait until the last write has occurred, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Timing: if start is sampled at edge k, then
  - rd_addr=i with rd_en=1 is presented in cycle k+1+i;
  - the write for index i is in cycle k+1+i+L, with wr_addr=i and wr_en=1;
  - done is high in cycle k+N+L+1.
- wr_en is generated by a valid shift register of depth RAM_LAT+max(LAT_PRE,LAT_NORM). rd_en enters the register; the tap is selected by mode.
- wr_addr is a counter that increments after each write.
- Exactly N writes per operation, on N consecutive cycles. The write sequence has no gaps.
- mult_en=1 and mult_precomp=mode from the cycle after start is accepted through the last write; both are 0 in IDLE. mode is stable for the whole operation.
- Counter terminal value is N-1; no counter wraps past N-1 within an operation. Both counters return to 0 on entry to IDLE.
- start while busy or in DONE: ignored, with no effect on the current run.
- start in the same cycle done is high: ignored. A new start is accepted only when the FSM is already in IDLE.
- Changes on precomp_in after acceptance: no effect.
- rst mid-operation: everything returns to reset values next cycle. No further wr_en is asserted, including in-flight pipeline entries, and no done pulse is produced.

Test Plan:
Every scenario uses N=8, RAM_LAT=1, LAT_PRE=4, LAT_NORM=8. The bench multiplier stub returns the value 100+addr after the mode latency.
1. Normal run: start at edge 0 with precomp_in=0 -> rd_addr 0..7 in cycles 1..8; wr_en in cycles 10..17 with wr_addr 0..7 and wr_data 100..107; done only in cycle 18; busy high in cycles 1..18.
2. Precomp run: start with precomp_in=1 -> mult_precomp=1; L=5; writes in cycles 6..13; done in cycle 14.
3. Mode latch: precomp_in toggled every cycle during a precomp run -> mult_precomp stays 1; the write schedule is identical to scenario 2.
4. start pulses during RUN, DRAIN and the done cycle -> exactly one run, 8 writes, one done pulse. A start one cycle after done -> new run begins with rd_addr=0 and wr_addr=0.
5. rst asserted in cycle 5 of a normal run -> cycle 6 onward all outputs are 0; no wr_en and no done afterwards. A following start -> a full, correct 8-write run.
6. Back-to-back runs, precomp then normal -> each run produces 8 writes with addresses 0..7 and correct latencies (5, then 9), with no writes overlapping between runs.
